// File: rtl/saxil_read_arbiter_if.sv
// AXI4-Lite read-channel bundle (AR + R) shared by the arbiter's master-facing
// and slave-facing ports.
interface saxil_read_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;

  modport master (
    output arvalid, araddr, arprot, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, arprot, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/saxil_read_arbiter.sv
// Two-master round-robin arbiter in front of one AXI4-Lite read slave.
// A single read is in flight: capture the AR, issue it downstream, route R back.
module saxil_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  saxil_read_arbiter_clk,
  input  logic                  saxil_read_arbiter_rst_n,
  saxil_read_arbiter_if.slave   m0,
  saxil_read_arbiter_if.slave   m1,
  saxil_read_arbiter_if.master  s
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                state_r, state_s;
  logic                  last_grant_r, last_grant_s;
  logic                  grant_r, grant_s;
  logic [ADDR_WIDTH-1:0] araddr_r, araddr_s;
  logic [2:0]            arprot_r, arprot_s;
  logic                  req_s, win_s;
  logic                  m0_arready_s, m1_arready_s;
  logic                  m0_rvalid_s, m1_rvalid_s;
  logic                  s_arvalid_s, s_rready_s;
  logic [DATA_WIDTH-1:0] m0_rdata_s, m1_rdata_s;
  logic [1:0]            m0_rresp_s, m1_rresp_s;

  // Winner selection: on contention the master not served last time wins.
  always_comb begin
    req_s = m0.arvalid | m1.arvalid;
    win_s = 1'b0;
    if (m0.arvalid && m1.arvalid) begin
      win_s = ~last_grant_r;
    end else if (m1.arvalid) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Next-state and handshake/routing outputs.
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    grant_s      = grant_r;
    araddr_s     = araddr_r;
    arprot_s     = arprot_r;
    m0_arready_s = 1'b0;
    m1_arready_s = 1'b0;
    m0_rvalid_s  = 1'b0;
    m1_rvalid_s  = 1'b0;
    m0_rdata_s   = {DATA_WIDTH{1'b0}};
    m1_rdata_s   = {DATA_WIDTH{1'b0}};
    m0_rresp_s   = 2'b00;
    m1_rresp_s   = 2'b00;
    s_arvalid_s  = 1'b0;
    s_rready_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          state_s = ST_ADDR;
          grant_s = win_s;
          if (win_s == 1'b0) begin
            m0_arready_s = 1'b1;
            araddr_s     = m0.araddr;
            arprot_s     = m0.arprot;
          end else begin
            m1_arready_s = 1'b1;
            araddr_s     = m1.araddr;
            arprot_s     = m1.arprot;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        s_arvalid_s = 1'b1;
        if (s.arready) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (grant_r == 1'b0) begin
          m0_rvalid_s = s.rvalid;
          m0_rdata_s  = s.rdata;
          m0_rresp_s  = s.rresp;
          s_rready_s  = m0.rready;
        end else begin
          m1_rvalid_s = s.rvalid;
          m1_rdata_s  = s.rdata;
          m1_rresp_s  = s.rresp;
          s_rready_s  = m1.rready;
        end
        if (s.rvalid && s_rready_s) begin
          state_s      = ST_IDLE;
          last_grant_s = grant_r;
        end else begin
          state_s = ST_DATA;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, grant history and captured AR fields.
  always_ff @(posedge saxil_read_arbiter_clk) begin
    if (!saxil_read_arbiter_rst_n) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      grant_r      <= 1'b0;
      araddr_r     <= {ADDR_WIDTH{1'b0}};
      arprot_r     <= 3'b000;
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      grant_r      <= grant_s;
      araddr_r     <= araddr_s;
      arprot_r     <= arprot_s;
    end
  end

  // Outputs are forced quiet while reset is asserted so an abandoned beat never leaks.
  assign m0.arready = saxil_read_arbiter_rst_n & m0_arready_s;
  assign m1.arready = saxil_read_arbiter_rst_n & m1_arready_s;
  assign m0.rvalid  = saxil_read_arbiter_rst_n & m0_rvalid_s;
  assign m1.rvalid  = saxil_read_arbiter_rst_n & m1_rvalid_s;
  assign m0.rdata   = saxil_read_arbiter_rst_n ? m0_rdata_s : {DATA_WIDTH{1'b0}};
  assign m1.rdata   = saxil_read_arbiter_rst_n ? m1_rdata_s : {DATA_WIDTH{1'b0}};
  assign m0.rresp   = saxil_read_arbiter_rst_n ? m0_rresp_s : 2'b00;
  assign m1.rresp   = saxil_read_arbiter_rst_n ? m1_rresp_s : 2'b00;
  assign s.arvalid  = saxil_read_arbiter_rst_n & s_arvalid_s;
  assign s.rready   = saxil_read_arbiter_rst_n & s_rready_s;
  assign s.araddr   = araddr_r;
  assign s.arprot   = arprot_r;

endmodule

// File: tb/tb_saxil_read_arbiter.sv
// Randomized and directed bench for saxil_read_arbiter against a transaction-level
// reference model (request queues, a busy/sent phase pair and a priority pointer).
module tb_saxil_read_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  saxil_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_bus ();
  saxil_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_bus ();
  saxil_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_bus ();

  saxil_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .saxil_read_arbiter_clk   (clk),
    .saxil_read_arbiter_rst_n (rst_n),
    .m0                       (m0_bus),
    .m1                       (m1_bus),
    .s                        (s_bus)
  );

  // stimulus
  logic [1:0]    arv  = 2'b00;
  logic [1:0]    rrdy = 2'b11;
  logic [1:0]    en   = 2'b11;
  logic [AW-1:0] addr [2];
  logic [2:0]    prot [2];
  logic          s_ardy = 1'b0;
  logic          s_rv   = 1'b0;
  logic [DW-1:0] s_rd   = 32'h0;
  logic [1:0]    s_rr   = 2'b00;

  assign m0_bus.arvalid = arv[0];
  assign m0_bus.araddr  = addr[0];
  assign m0_bus.arprot  = prot[0];
  assign m0_bus.rready  = rrdy[0];
  assign m1_bus.arvalid = arv[1];
  assign m1_bus.araddr  = addr[1];
  assign m1_bus.arprot  = prot[1];
  assign m1_bus.rready  = rrdy[1];
  assign s_bus.arready  = s_ardy;
  assign s_bus.rvalid   = s_rv;
  assign s_bus.rdata    = s_rd;
  assign s_bus.rresp    = s_rr;

  // pending requests per master: {prot, addr}
  logic [AW+2:0] q0[$];
  logic [AW+2:0] q1[$];

  // reference model
  bit            busy = 1'b0;
  bit            sent = 1'b0;
  int            g    = 0;
  int            last = 1;
  logic [AW-1:0] held_addr = 32'h0;
  logic [2:0]    held_prot = 3'b000;
  int            done_cnt [2];

  // bench slave
  int            ar_dly = 0, r_dly = 0, ar_cnt = 0, r_cnt = 0;
  bit            slv_pend = 1'b0;
  bit            rand_mode = 1'b0;
  logic [DW-1:0] slv_data = 32'h0;
  logic [1:0]    slv_resp = 2'b00;

  // observations of the DUT
  int            obs_grant[$];
  logic [AW-1:0] obs_addr[$];
  int            beats [2];
  int            rv_seen [2];
  logic [DW-1:0] last_rdata [2];
  int            addr_cyc = 0;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int qsize(input int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [AW+2:0] qfront(input int m);
    if (m == 0) return q0[0];
    return q1[0];
  endfunction

  task automatic qpush(input int m, input logic [AW+2:0] v);
    if (m == 0) q0.push_back(v);
    else q1.push_back(v);
  endtask

  task automatic qpop(input int m);
    if (m == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  task automatic apply_inputs();
    for (int m = 0; m < 2; m++) begin
      if (rand_mode) begin
        en[m]   = ($urandom_range(0, 3) != 0);
        rrdy[m] = ($urandom_range(0, 2) != 0);
        if (qsize(m) < 3 && $urandom_range(0, 3) == 0)
          qpush(m, {3'($urandom_range(0, 7)), 32'($urandom)});
      end
      if (qsize(m) > 0) begin
        arv[m] = en[m];
        {prot[m], addr[m]} = qfront(m);
      end else begin
        arv[m]  = 1'b0;
        addr[m] = 32'($urandom);
        prot[m] = 3'($urandom_range(0, 7));
      end
    end
    s_ardy = s_bus.arvalid && (ar_cnt >= ar_dly);
    s_rv   = slv_pend && (r_cnt >= r_dly);
    s_rd   = s_rv ? slv_data : 32'($urandom);
    s_rr   = s_rv ? slv_resp : 2'($urandom_range(0, 3));
  endtask

  // One clock: check at negedge, advance model at posedge, drive new inputs at +1.
  task automatic step();
    int            w;
    bit            req, ar_hs, r_hs, sav;
    logic [1:0]    exp_ar, exp_rv, obs_ar;
    logic [DW-1:0] exp_d0, exp_d1;
    logic [3:0]    exp_rr;
    logic          exp_srr;
    @(negedge clk);
    req = (arv != 2'b00);
    if (arv == 2'b11) w = 1 - last;
    else if (arv[0]) w = 0;
    else w = 1;
    exp_ar = 2'b00;
    if (rst_n && !busy && req) exp_ar[w] = 1'b1;
    obs_ar = {m1_bus.arready, m0_bus.arready};
    check_eq("arready", 64'(obs_ar), 64'(exp_ar));
    check_eq("s_arvalid", 64'(s_bus.arvalid), 64'(rst_n && busy && !sent));
    check_eq("s_araddr", 64'(s_bus.araddr), 64'(held_addr));
    check_eq("s_arprot", 64'(s_bus.arprot), 64'(held_prot));
    exp_rv = 2'b00; exp_d0 = 32'h0; exp_d1 = 32'h0; exp_rr = 4'h0; exp_srr = 1'b0;
    if (rst_n && busy && sent) begin
      exp_rv[g] = s_rv;
      exp_srr   = rrdy[g];
      if (g == 0) begin exp_d0 = s_rd; exp_rr[1:0] = s_rr; end
      else begin exp_d1 = s_rd; exp_rr[3:2] = s_rr; end
    end
    check_eq("rvalid", 64'({m1_bus.rvalid, m0_bus.rvalid}), 64'(exp_rv));
    check_eq("m0_rdata", 64'(m0_bus.rdata), 64'(exp_d0));
    check_eq("m1_rdata", 64'(m1_bus.rdata), 64'(exp_d1));
    check_eq("rresp", 64'({m1_bus.rresp, m0_bus.rresp}), 64'(exp_rr));
    check_eq("s_rready", 64'(s_bus.rready), 64'(exp_srr));
    sav   = s_bus.arvalid;
    ar_hs = sav && s_ardy;
    r_hs  = s_rv && s_bus.rready;
    if (sav) addr_cyc++;
    if (m0_bus.rvalid) rv_seen[0]++;
    if (m1_bus.rvalid) rv_seen[1]++;
    if (rst_n && obs_ar != 2'b00) obs_grant.push_back(obs_ar[1] ? 1 : 0);
    if (rst_n && ar_hs) obs_addr.push_back(s_bus.araddr);
    if (rst_n && m0_bus.rvalid && rrdy[0]) begin beats[0]++; last_rdata[0] = m0_bus.rdata; end
    if (rst_n && m1_bus.rvalid && rrdy[1]) begin beats[1]++; last_rdata[1] = m1_bus.rdata; end
    @(posedge clk);
    if (!rst_n) begin
      busy = 1'b0; sent = 1'b0; last = 1; held_addr = 32'h0; held_prot = 3'b000;
      slv_pend = 1'b0; ar_cnt = 0; r_cnt = 0;
    end else begin
      if (!busy) begin
        if (req) begin
          busy = 1'b1; sent = 1'b0; g = w; held_addr = addr[w]; held_prot = prot[w];
        end
      end else if (!sent) begin
        if (s_ardy) sent = 1'b1;
      end else if (s_rv && rrdy[g]) begin
        busy = 1'b0; last = g; done_cnt[g]++;
      end
      for (int m = 0; m < 2; m++)
        if (obs_ar[m] && arv[m]) qpop(m);
      if (ar_hs) begin
        slv_pend = 1'b1; r_cnt = 0; ar_cnt = 0;
        if (rand_mode) r_dly = $urandom_range(0, 3);
      end else if (sav) begin
        ar_cnt++;
      end
      if (r_hs) begin
        slv_pend = 1'b0;
        slv_data = rand_mode ? 32'($urandom) : slv_data + 32'h0101_0101;
        if (rand_mode) begin
          slv_resp = 2'($urandom_range(0, 3));
          ar_dly   = $urandom_range(0, 3);
        end
      end else if (slv_pend) begin
        r_cnt++;
      end
    end
    #1;
    apply_inputs();
  endtask

  task automatic drain(input string tag, input int budget, output int n);
    n = 0;
    while ((busy || qsize(0) > 0 || qsize(1) > 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check_eq({tag, "_timeout"}, 64'(1), 64'(0));
  endtask

  task automatic wait_rvalid(input string tag);
    int n = 0;
    while (!(busy && sent && s_rv) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check_eq({tag, "_timeout"}, 64'(1), 64'(0));
  endtask

  initial begin
    int n;
    addr[0] = 32'h0; addr[1] = 32'h0; prot[0] = 3'b000; prot[1] = 3'b000;
    done_cnt[0] = 0; done_cnt[1] = 0; beats[0] = 0; beats[1] = 0;
    rv_seen[0] = 0; rv_seen[1] = 0;
    last_rdata[0] = 32'h0; last_rdata[1] = 32'h0;
    apply_inputs();
    repeat (2) @(posedge clk);
    #1;

    // T1: reset with both masters requesting
    qpush(0, {3'b001, 32'h0000_1111});
    qpush(1, {3'b010, 32'h0000_2222});
    apply_inputs();
    step();
    q0.delete(); q1.delete();
    rst_n = 1'b1;
    apply_inputs();
    step();

    // T2: single master, zero-wait slave
    slv_data = 32'hDEAD_BEEF; slv_resp = 2'b00;
    obs_addr.delete(); beats[0] = 0; beats[1] = 0;
    qpush(0, {3'b000, 32'hFFFF_FFFF});
    apply_inputs();
    drain("t2", 20, n);
    check_eq("t2_latency", 64'(n), 64'(3));
    check_eq("t2_naddr", 64'(obs_addr.size()), 64'(1));
    if (obs_addr.size() > 0) check_eq("t2_addr", 64'(obs_addr[0]), 64'h0000_0000_FFFF_FFFF);
    check_eq("t2_data", 64'(last_rdata[0]), 64'h0000_0000_DEAD_BEEF);
    check_eq("t2_beats0", 64'(beats[0]), 64'(1));
    check_eq("t2_beats1", 64'(beats[1]), 64'(0));

    // T3: contention right after reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    obs_addr.delete(); obs_grant.delete();
    qpush(0, {3'b000, 32'h0000_0010});
    qpush(1, {3'b000, 32'h0000_0020});
    apply_inputs();
    drain("t3", 40, n);
    check_eq("t3_naddr", 64'(obs_addr.size()), 64'(2));
    if (obs_addr.size() >= 2) begin
      check_eq("t3_addr0", 64'(obs_addr[0]), 64'h10);
      check_eq("t3_addr1", 64'(obs_addr[1]), 64'h20);
      check_eq("t3_grant0", 64'(obs_grant[0]), 64'(0));
      check_eq("t3_grant1", 64'(obs_grant[1]), 64'(1));
    end

    // T4: both masters hold requests for four transactions
    obs_grant.delete(); beats[0] = 0; beats[1] = 0;
    for (int i = 0; i < 2; i++) begin
      qpush(0, {3'b011, 32'h0000_4000 + 32'(i)});
      qpush(1, {3'b100, 32'h0000_5000 + 32'(i)});
    end
    apply_inputs();
    drain("t4", 60, n);
    check_eq("t4_ngrant", 64'(obs_grant.size()), 64'(4));
    if (obs_grant.size() == 4)
      for (int i = 0; i < 4; i++) check_eq("t4_order", 64'(obs_grant[i]), 64'(i % 2));
    check_eq("t4_beats0", 64'(beats[0]), 64'(2));
    check_eq("t4_beats1", 64'(beats[1]), 64'(2));

    // T5: slow s_arready, m1 holds off rready for two cycles
    beats[0] = 0; beats[1] = 0; addr_cyc = 0; ar_dly = 3; rrdy[1] = 1'b0;
    qpush(1, {3'b101, 32'hA5A5_0004});
    apply_inputs();
    wait_rvalid("t5");
    step();
    step();
    rrdy[1] = 1'b1;
    drain("t5", 20, n);
    check_eq("t5_addr_cycles", 64'(addr_cyc), 64'(4));
    check_eq("t5_beats1", 64'(beats[1]), 64'(1));
    check_eq("t5_beats0", 64'(beats[0]), 64'(0));
    ar_dly = 0;

    // T6: reset while the slave R beat is about to arrive
    beats[0] = 0; rv_seen[0] = 0; r_dly = 2; rrdy[0] = 1'b0;
    qpush(0, {3'b000, 32'h0000_0060});
    apply_inputs();
    wait_rvalid("t6");
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; rrdy = 2'b11; r_dly = 0;
    step();
    check_eq("t6_rvalid_seen", 64'(rv_seen[0]), 64'(0));
    check_eq("t6_beats0", 64'(beats[0]), 64'(0));
    obs_grant.delete();
    qpush(1, {3'b000, 32'h0000_0070});
    qpush(0, {3'b000, 32'h0000_0080});
    apply_inputs();
    drain("t6", 40, n);
    if (obs_grant.size() > 0) check_eq("t6_first_grant", 64'(obs_grant[0]), 64'(0));
    else check_eq("t6_ngrant", 64'(obs_grant.size()), 64'(2));

    // Random traffic
    beats[0] = 0; beats[1] = 0; done_cnt[0] = 0; done_cnt[1] = 0;
    rand_mode = 1'b1;
    repeat (800) step();
    rand_mode = 1'b0; en = 2'b11; rrdy = 2'b11;
    apply_inputs();
    drain("rand", 400, n);
    check_eq("rand_beats0", 64'(beats[0]), 64'(done_cnt[0]));
    check_eq("rand_beats1", 64'(beats[1]), 64'(done_cnt[1]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
